wr_dispatch_ctrl: RTL
=====================

# wr_dispatch_ctrl

Write-side dispatcher placed behind the AXI write interface. It takes each single-beat internal write (`axi_wr_vld`/addr/data/strb/region), routes it to the output FIFO, the instruction RAM (IRAM) or the weight RAM (WRAM), and returns the matching `*_wr_done` pulse that releases the next beat. The WRAM port is shared with the compute core; the block arbitrates that port with a starvation guard. It also flags illegal regions, FIFO timeouts and protocol overruns.

## Interface
- `ADDR_WIDTH`, 11, internal write address width
- `DATA_WIDTH`, 32, write data width
- `STRB_WIDTH`, 4, byte-strobe width (`DATA_WIDTH/8`)
- `STARVE_LIMIT`, 8, consecutive cycles an AXI WRAM write may lose arbitration to the core before it is forced through
- `TIMEOUT`, 255, maximum DISPATCH cycles before the write is abandoned; must be greater than `STARVE_LIMIT`
- `clk  in  1  clock, rising edge`
- `rst  in  1  asynchronous, active-high reset`
- `axi_wr_vld  in  1  single-cycle pulse; the write beat is valid`
- `axi_wr_addr  in  ADDR_WIDTH  beat address`
- `axi_wr_data  in  DATA_WIDTH  beat data`
- `axi_wr_strb  in  STRB_WIDTH  beat byte strobes`
- `axi_wr_region  in  2  target: 0=FIFO, 1=IRAM, 2=WRAM, 3=illegal`
- `fifo_wr_done / iram_wr_done / wram_wr_done  out  1 each  one-cycle completion pulses back to the AXI write interface`
- `wr_err  out  1  asserted together with the done pulse when the beat was dropped`
- `ovf_err  out  1  sticky; `axi_wr_vld` was seen while the block was not IDLE`
- `fifo_wen  out  1`, `fifo_wdata  out  DATA_WIDTH`, `fifo_full  in  1`
- `iram_we  out  1`, `iram_addr  out  ADDR_WIDTH`, `iram_wdata  out  DATA_WIDTH`, `iram_wstrb  out  STRB_WIDTH`
- `wram_we  out  1`, `wram_addr  out  ADDR_WIDTH`, `wram_wdata  out  DATA_WIDTH`, `wram_wstrb  out  STRB_WIDTH`
- `core_wram_req  in  1`, `core_wram_addr  in  ADDR_WIDTH`, `core_wram_wdata  in  DATA_WIDTH`, `core_wram_wstrb  in  STRB_WIDTH`, `core_wram_gnt  out  1`

## Operation
- **FSM states:** IDLE, DISPATCH, DONE. Reset enters IDLE.
- **Capture:**
  - In IDLE, `axi_wr_vld` latches addr, data, strb and region into holding registers and moves to DISPATCH.
  - `axi_wr_vld` in DISPATCH or DONE is ignored and sets `ovf_err`. The holding registers are not overwritten.
- **DISPATCH, region 0 (FIFO):**
  - If `fifo_full`=0, drive `fifo_wen`=1 for exactly one cycle with the held data, then go to DONE.
  - Otherwise stay in DISPATCH.
- **DISPATCH, region 1 (IRAM):** `iram_we`=1 in the first DISPATCH cycle, then go to DONE. IRAM is never busy.
- **DISPATCH, region 2 (WRAM):** arbitration.
  - The core wins if `core_wram_req`=1 and the starvation count is below `STARVE_LIMIT`.
  - Otherwise the AXI write wins: `wram_we`=1 with the held addr/data/strb, then go to DONE.
- **DISPATCH, region 3:** go to DONE immediately with the error set. No write strobe is driven.
- **Timeout:** a DISPATCH cycle counter (8-bit, saturating) reaches `TIMEOUT` → abandon the write (no strobe), go to DONE with the error set. In practice this only occurs on a FIFO target.
- **DONE:**
  - Pulse exactly one done line for one cycle: FIFO/region 3 → `fifo_wr_done`, IRAM → `iram_wr_done`, WRAM → `wram_wr_done`.
  - `wr_err` is high in the same cycle if the beat was dropped.
  - Return to IDLE.
- **Starvation counter:** cleared on entering DISPATCH. It increments each WRAM DISPATCH cycle in which the core wins, and saturates at `STARVE_LIMIT`.
- **WRAM mux:**
  - `core_wram_gnt` = `core_wram_req` & ~(AXI wins this cycle); combinational.
  - When the core is granted, the `wram_*` outputs carry the core signals and `wram_we` = `core_wram_req`.
  - In all non-WRAM states the core is granted whenever it requests.

## Timing
- **Reset values:** all strobes, done pulses, `wr_err`, `ovf_err` and `core_wram_gnt` are 0. Data/address outputs are 0.
- **Best-case latency:** `axi_wr_vld` in cycle 0 → write strobe in cycle 1 → done pulse in cycle 2.
- **FIFO stall:** each cycle of `fifo_full` adds one cycle of latency.
- **WRAM contention:** adds at most `STARVE_LIMIT` cycles.
- **Register timing:** done pulses and `wr_err` are registered. Write strobes and `core_wram_gnt` are decoded from state in the same cycle.
- **Simultaneous events:**
  - `fifo_full` falling in the same cycle the timeout is reached: the write wins and `wr_err`=0.
  - Core request in the forced-AXI cycle: the core sees `core_wram_gnt`=0 and must hold its request.
- **Reset mid-operation:** any in-flight beat is discarded without a done pulse, and `ovf_err` clears.

## Test plan
- IRAM write: region 1, addr 0x012, data 0xDEADBEEF, strb 0xF → `iram_we` in cycle 1 with those values; `iram_wr_done` in cycle 2; `wr_err`=0.
- FIFO backpressure: region 0 with `fifo_full` held for 5 cycles → `fifo_wen` in cycle 6; `fifo_wr_done` in cycle 7.
- FIFO timeout: `fifo_full` stuck high, TIMEOUT=255 → no `fifo_wen`; `fifo_wr_done`=1 and `wr_err`=1 exactly 256 cycles after DISPATCH entry.
- WRAM starvation: `core_wram_req` constantly high, STARVE_LIMIT=8 → core granted 8 cycles; AXI `wram_we` with held addr in the 9th; `core_wram_gnt`=0 in that cycle; `wram_wr_done` next cycle.
- Illegal region and overrun: region 3 → `fifo_wr_done`+`wr_err` in cycle 2 with no strobes. A second `axi_wr_vld` during DISPATCH → `ovf_err`=1 and stays high until `rst`.
- Reset mid-WRAM-wait: assert `rst` during DISPATCH → all outputs return to 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/wr_dispatch_ctrl.sv
// Write-side dispatcher: routes single-beat internal writes to FIFO, IRAM or
// WRAM, arbitrates the shared WRAM port against the compute core with a
// starvation guard, and returns one completion pulse per beat.
module wr_dispatch_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STRB_WIDTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_wr_vld,
  input  logic [ADDR_WIDTH-1:0] axi_wr_addr,
  input  logic [DATA_WIDTH-1:0] axi_wr_data,
  input  logic [STRB_WIDTH-1:0] axi_wr_strb,
  input  logic [1:0]            axi_wr_region,
  output logic                  fifo_wr_done,
  output logic                  iram_wr_done,
  output logic                  wram_wr_done,
  output logic                  wr_err,
  output logic                  ovf_err,
  output logic                  fifo_wen,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_full,
  output logic                  iram_we,
  output logic [ADDR_WIDTH-1:0] iram_addr,
  output logic [DATA_WIDTH-1:0] iram_wdata,
  output logic [STRB_WIDTH-1:0] iram_wstrb,
  output logic                  wram_we,
  output logic [ADDR_WIDTH-1:0] wram_addr,
  output logic [DATA_WIDTH-1:0] wram_wdata,
  output logic [STRB_WIDTH-1:0] wram_wstrb,
  input  logic                  core_wram_req,
  input  logic [ADDR_WIDTH-1:0] core_wram_addr,
  input  logic [DATA_WIDTH-1:0] core_wram_wdata,
  input  logic [STRB_WIDTH-1:0] core_wram_wstrb,
  output logic                  core_wram_gnt
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] REG_FIFO = 2'd0;
  localparam logic [1:0] REG_IRAM = 2'd1;
  localparam logic [1:0] REG_WRAM = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [STRB_WIDTH-1:0] hold_strb;
  logic [1:0]            hold_region;
  logic [CNT_W-1:0]      timeout_cnt;
  logic [CNT_W-1:0]      starve_cnt;

  logic in_disp_c, core_wins_c, axi_win_c, fifo_go_c, iram_go_c, timeout_c;

  // Per-cycle dispatch decisions decoded from the current state
  always_comb begin
    in_disp_c   = (state == ST_DISPATCH);
    core_wins_c = core_wram_req && (starve_cnt < CNT_W'(STARVE_LIMIT));
    axi_win_c   = in_disp_c && (hold_region == REG_WRAM) && !core_wins_c;
    fifo_go_c   = in_disp_c && (hold_region == REG_FIFO) && !fifo_full;
    iram_go_c   = in_disp_c && (hold_region == REG_IRAM);
    timeout_c   = (timeout_cnt >= CNT_W'(TIMEOUT));
  end

  // Write strobes and WRAM port mux; data buses idle at zero
  always_comb begin
    core_wram_gnt = core_wram_req && !axi_win_c && !rst;
    fifo_wen      = fifo_go_c;
    fifo_wdata    = fifo_go_c ? hold_data : '0;
    iram_we       = iram_go_c;
    iram_addr     = iram_go_c ? hold_addr : '0;
    iram_wdata    = iram_go_c ? hold_data : '0;
    iram_wstrb    = iram_go_c ? hold_strb : '0;
    wram_we       = axi_win_c || core_wram_gnt;
    wram_addr     = '0;
    wram_wdata    = '0;
    wram_wstrb    = '0;
    if (axi_win_c) begin
      wram_addr  = hold_addr;
      wram_wdata = hold_data;
      wram_wstrb = hold_strb;
    end else if (core_wram_gnt) begin
      wram_addr  = core_wram_addr;
      wram_wdata = core_wram_wdata;
      wram_wstrb = core_wram_wstrb;
    end
  end

  // FSM, holding registers, counters and registered done/error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      hold_addr    <= '0;
      hold_data    <= '0;
      hold_strb    <= '0;
      hold_region  <= '0;
      timeout_cnt  <= '0;
      starve_cnt   <= '0;
      fifo_wr_done <= 1'b0;
      iram_wr_done <= 1'b0;
      wram_wr_done <= 1'b0;
      wr_err       <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      fifo_wr_done <= 1'b0;
      iram_wr_done <= 1'b0;
      wram_wr_done <= 1'b0;
      wr_err       <= 1'b0;
      if (axi_wr_vld && (state != ST_IDLE)) ovf_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (axi_wr_vld) begin
            hold_addr   <= axi_wr_addr;
            hold_data   <= axi_wr_data;
            hold_strb   <= axi_wr_strb;
            hold_region <= axi_wr_region;
            timeout_cnt <= '0;
            starve_cnt  <= '0;
            state       <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
          case (hold_region)
            REG_FIFO: begin
              // A write that becomes possible in the timeout cycle still wins
              if (!fifo_full) begin
                fifo_wr_done <= 1'b1;
                state        <= ST_DONE;
              end else if (timeout_c) begin
                fifo_wr_done <= 1'b1;
                wr_err       <= 1'b1;
                state        <= ST_DONE;
              end
            end
            REG_IRAM: begin
              iram_wr_done <= 1'b1;
              state        <= ST_DONE;
            end
            REG_WRAM: begin
              if (!core_wins_c) begin
                wram_wr_done <= 1'b1;
                state        <= ST_DONE;
              end else begin
                starve_cnt <= starve_cnt + CNT_W'(1);
                if (timeout_c) begin
                  wram_wr_done <= 1'b1;
                  wr_err       <= 1'b1;
                  state        <= ST_DONE;
                end
              end
            end
            default: begin
              fifo_wr_done <= 1'b1;
              wr_err       <= 1'b1;
              state        <= ST_DONE;
            end
          endcase
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
